// File: rtl/alarm_ctrl_pkg.sv
// alarm_ctrl_pkg: FSM encoding, button indices and BCD time-word layout.
// Shared by the alarm, clock and display blocks.
package alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RINGING   = 2'd1,
    ST_SNOOZE    = 2'd2,
    ST_DISMISSED = 2'd3
  } state_e;

  localparam int DIGIT_W = 4;
  localparam int M0_LSB  = 0;
  localparam int M1_LSB  = 4;
  localparam int H0_LSB  = 8;
  localparam int H1_LSB  = 12;

  localparam int BTN_SNOOZE = 0;
  localparam int BTN_STOP   = 1;

  function automatic logic [DIGIT_W-1:0] bcd_digit(
    input logic [15:0] t,
    input int          lsb
  );
    return t[lsb +: DIGIT_W];
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: time/alarm inputs, buttons and buzzer/status outputs.
// master drives the inputs, slave is the alarm controller.
interface alarm_ctrl_if;

  logic [15:0] alarm_ctrl_time;
  logic [15:0] alarm_ctrl_alarm;
  logic        alarm_ctrl_en;
  logic        alarm_ctrl_snooze;
  logic        alarm_ctrl_stop;
  logic        alarm_ctrl_buzz;
  logic        alarm_ctrl_ringing;
  logic        alarm_ctrl_snoozing;
  logic        alarm_ctrl_missed;
  logic [1:0]  alarm_ctrl_snooze_cnt;

  modport master (
    output alarm_ctrl_time, alarm_ctrl_alarm, alarm_ctrl_en,
    output alarm_ctrl_snooze, alarm_ctrl_stop,
    input  alarm_ctrl_buzz, alarm_ctrl_ringing, alarm_ctrl_snoozing,
    input  alarm_ctrl_missed, alarm_ctrl_snooze_cnt
  );

  modport slave (
    input  alarm_ctrl_time, alarm_ctrl_alarm, alarm_ctrl_en,
    input  alarm_ctrl_snooze, alarm_ctrl_stop,
    output alarm_ctrl_buzz, alarm_ctrl_ringing, alarm_ctrl_snoozing,
    output alarm_ctrl_missed, alarm_ctrl_snooze_cnt
  );

endinterface

// File: rtl/alarm_ctrl_tick.sv
// alarm_ctrl_tick: divide-by-DIV counter emitting a 1-cycle pulse.
// clr_i holds the count at zero; en_i gates counting.
module alarm_ctrl_tick #(
  parameter int DIV = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic pulse_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         last;

  assign last    = (cnt_q == W'(DIV - 1));
  assign pulse_o = en_i & ~clr_i & last;

  // Next count: clear, wrap at DIV-1, or advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm FSM with snooze, dismiss, ring timeout and gated buzzer.
// Define ALARM_CTRL_DEBOUNCE_EN to add a stability filter on the buttons.
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int TONE_DIV   = 50000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic        alarm_ctrl_clk,
  input  logic        alarm_ctrl_rst,
  alarm_ctrl_if.slave bus
);

  localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);

  localparam logic [SEC_W-1:0] RING_LIM = SEC_W'(RING_SEC);
  localparam logic [SEC_W-1:0] SNZ_LIM  = SEC_W'(SNOOZE_SEC);
  localparam logic [1:0]       SNZ_MAX  = 2'(MAX_SNOOZE);

  logic clk;
  logic rst_n;

  assign clk   = alarm_ctrl_clk;
  assign rst_n = alarm_ctrl_rst;

  state_e state_q, state_d;

  logic             match, match_q, trig;
  logic             tick, tone_tick;
  logic             in_ring, in_snz;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [1:0]       snz_q, snz_d;
  logic             missed_q, missed_d;
  logic             beat_q, beat_d;
  logic             tone_q, tone_d;

  logic [1:0] btn_raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] lvl, prev_q;
  logic [1:0] arm_q, arm_d;
  logic [1:0] btn_edge;
  logic [1:0] boot_q, boot_d;
  logic       boot_done;
  logic       stop_e, snz_e;

  logic ringing_o, snoozing_o, buzz_o;

  assign btn_raw[BTN_SNOOZE] = bus.alarm_ctrl_snooze;
  assign btn_raw[BTN_STOP]   = bus.alarm_ctrl_stop;

  // Synchronizer, post-reset fill counter and edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
      boot_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= lvl;
      arm_q   <= arm_d;
      boot_q  <= boot_d;
    end
  end

  // A button only arms once seen released after reset,
  // so one held through reset cannot fire.
  assign boot_done = (boot_q == 2'd2);
  assign boot_d    = boot_done ? boot_q : boot_q + 2'd1;
  assign arm_d     = arm_q | ({2{boot_done}} & ~sync2_q);

`ifdef ALARM_CTRL_DEBOUNCE_EN
  localparam int DB_CYCLES = (TICK_DIV / 100 > 0) ? TICK_DIV / 100 : 1;
  localparam int DB_W      = $clog2(DB_CYCLES + 1);

  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           flt_q, flt_d;

  // Filter: adopt the synced level after DB_CYCLES stable cycles.
  always_comb begin
    flt_d    = flt_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != flt_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          flt_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Filter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      flt_q    <= flt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign lvl = flt_q;
`else
  assign lvl = sync2_q;
`endif

  assign btn_edge = lvl & ~prev_q & arm_q;
  assign stop_e   = btn_edge[BTN_STOP];
  assign snz_e    = btn_edge[BTN_SNOOZE];

  assign match   = (bus.alarm_ctrl_time == bus.alarm_ctrl_alarm);
  assign trig    = match & ~match_q & bus.alarm_ctrl_en;
  assign in_ring = (state_q == ST_RINGING);
  assign in_snz  = (state_q == ST_SNOOZE);

  alarm_ctrl_tick #(.DIV(TICK_DIV)) u_sec_tick (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (1'b1),
    .clr_i   (1'b0),
    .pulse_o (tick)
  );

  alarm_ctrl_tick #(.DIV(TONE_DIV)) u_tone_tick (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (in_ring),
    .clr_i   (~in_ring),
    .pulse_o (tone_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state with snooze count and missed flag; disarm wins.
  always_comb begin
    state_d  = state_q;
    snz_d    = snz_q;
    missed_d = missed_q;
    if (!bus.alarm_ctrl_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_d  = ST_RINGING;
            snz_d    = '0;
            missed_d = 1'b0;
          end
        end
        ST_RINGING: begin
          if (stop_e) begin
            state_d = ST_DISMISSED;
          end else if (snz_e && (snz_q < SNZ_MAX)) begin
            state_d = ST_SNOOZE;
            snz_d   = snz_q + 2'd1;
          end else if (sec_q >= RING_LIM) begin
            state_d  = ST_DISMISSED;
            missed_d = 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (stop_e) begin
            state_d = ST_DISMISSED;
          end else if (sec_q >= SNZ_LIM) begin
            state_d = ST_RINGING;
          end
        end
        ST_DISMISSED: begin
          if (!match) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Seconds in state, 0.5 Hz beat gate and tone phase.
  always_comb begin
    sec_d  = sec_q;
    beat_d = beat_q;
    tone_d = tone_q;
    if (state_d != state_q) begin
      sec_d = '0;
    end else if ((in_ring || in_snz) && tick) begin
      sec_d = sec_q + 1'b1;
    end
    if ((state_d == ST_RINGING) && !in_ring) begin
      beat_d = 1'b1;
    end else if (in_ring && tick) begin
      beat_d = ~beat_q;
    end
    if (!in_ring) begin
      tone_d = 1'b0;
    end else if (tone_tick) begin
      tone_d = ~tone_q;
    end
  end

  // Match history, counters and buzzer phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q  <= 1'b0;
      sec_q    <= '0;
      snz_q    <= '0;
      missed_q <= 1'b0;
      beat_q   <= 1'b0;
      tone_q   <= 1'b0;
    end else begin
      match_q  <= match;
      sec_q    <= sec_d;
      snz_q    <= snz_d;
      missed_q <= missed_d;
      beat_q   <= beat_d;
      tone_q   <= tone_d;
    end
  end

  // Output decode: flags follow state, buzz is the gated tone.
  always_comb begin
    ringing_o  = 1'b0;
    snoozing_o = 1'b0;
    buzz_o     = 1'b0;
    unique case (state_q)
      ST_RINGING: begin
        ringing_o = 1'b1;
        buzz_o    = tone_q & beat_q;
      end
      ST_SNOOZE: snoozing_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.alarm_ctrl_ringing    = ringing_o;
  assign bus.alarm_ctrl_snoozing   = snoozing_o;
  assign bus.alarm_ctrl_buzz       = buzz_o;
  assign bus.alarm_ctrl_missed     = missed_q;
  assign bus.alarm_ctrl_snooze_cnt = snz_q;

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Consumes the BCD current time (HH:MM, 16 bits) and the BCD alarm setting produced by the clock block.
- Decides when the alarm rings, and handles snooze, dismiss and ring timeout.
- Drives a gated square-wave buzzer output and status flags.
- Sits between the clock block and the board I/O (buzzer pin, LEDs); runs on the system clock.

Parameters:
- TICK_DIV, 100000000, system-clock cycles per 1 s tick.
- TONE_DIV, 50000, cycles per buzzer half-period (1 kHz at 100 MHz).
- RING_SEC, 60, seconds of ringing before auto-stop.
- SNOOZE_SEC, 300, snooze duration in seconds.
- MAX_SNOOZE, 3, snoozes allowed per alarm event.

Ports:
- alarm_ctrl_clk  in  1  system clock.
- alarm_ctrl_rst  in  1  asynchronous, active-low reset.
- alarm_ctrl_time  in  16  current time, BCD {H1,H0,M1,M0}.
- alarm_ctrl_alarm  in  16  alarm setting, same format.
- alarm_ctrl_en  in  1  alarm armed switch (level).
- alarm_ctrl_snooze  in  1  snooze button (level).
- alarm_ctrl_stop  in  1  stop button (level).
- alarm_ctrl_buzz  out  1  buzzer drive.
- alarm_ctrl_ringing  out  1  high in RINGING.
- alarm_ctrl_snoozing  out  1  high in SNOOZE.
- alarm_ctrl_missed  out  1  sticky flag: ring timed out without user action.
- alarm_ctrl_snooze_cnt  out  2  snoozes used in current event.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; tick/tone/second counters 0; match_q 0; button history 0.
- match = (time == alarm), full 16-bit compare. match_q is match registered each cycle.
- Trigger = match & !match_q & en.
- Buttons are rising-edge detected internally (registered previous level). A button held through reset does not fire until released and pressed again.
- Tick: 1-cycle pulse every TICK_DIV cycles, free-running from reset. Second counter sec_cnt (width clog2 of max(RING_SEC, SNOOZE_SEC)+1) counts ticks only in RINGING/SNOOZE and clears on every state change.
- FSM, one transition per cycle:
  - IDLE: trigger -> RINGING; snooze_cnt <= 0.
  - RINGING:
    - stop edge -> DISMISSED.
    - else snooze edge & snooze_cnt < MAX_SNOOZE -> SNOOZE, snooze_cnt+1.
    - snooze edge at limit is ignored.
    - else sec_cnt reaches RING_SEC -> DISMISSED, missed <= 1.
  - SNOOZE: stop edge -> DISMISSED; sec_cnt reaches SNOOZE_SEC -> RINGING.
  - DISMISSED: match low -> IDLE. This prevents re-trigger in the same minute.
- en low in any state -> IDLE next cycle (highest priority). snooze_cnt holds; missed holds.
- Stop has priority over snooze when both edge in the same cycle.
- missed clears on the next trigger or on reset only.
- Latency: ringing rises on the first clk edge at which trigger is true (1 cycle after time equality is presented).
- Buzzer:
  - tone toggles every TONE_DIV cycles while RINGING.
  - buzz = tone & beat, where beat toggles on each tick (0.5 Hz gating; beat resets to 1 on RINGING entry).
  - buzz = 0 in all other states.
  - Tone counter clears on leaving RINGING.
- Alarm value changing mid-RINGING does not stop ringing. Time wrapping 23:59 -> 00:00 is a plain value change, with no special case.

Optional Feature:
- Macro ALARM_CTRL_DEBOUNCE_EN.
- Defined: snooze and stop each pass through a 2-flop synchronizer plus a stability filter. Output updates only after the input is stable for DB_CYCLES = TICK_DIV/100 cycles; edge detection follows the filtered value. Adds 2 + DB_CYCLES cycles of button latency.
- Undefined: 2-flop synchronizer only, then edge detect.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, RINGING=1, SNOOZE=2, DISMISSED=3) and BCD digit field offsets for the 16-bit time word (reusable by display and clock blocks).
- One sub-module: alarm_ctrl_tick (parameterized divider emitting 1-cycle pulse; instanced twice, for the second tick and the tone toggle).
- The debounce filter stays inline under the macro.

Test Plan (sim with TICK_DIV=10, TONE_DIV=2, RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2):
1. Reset and trigger: reset low 5 cycles -> all outputs 0. alarm=0x0730, en=1, time 0x0729 -> 0x0730 -> ringing=1 after 1 edge; buzz toggles every 2 cycles during beat-high seconds.
2. Timeout: trigger, no buttons -> after 4 ticks, DISMISSED, ringing=0, missed=1. Hold time=0x0730 -> no re-trigger. Time 0x0731 -> IDLE.
3. Snooze: snooze pulse while RINGING -> snoozing=1, snooze_cnt=1; after 3 ticks ringing=1. Repeat -> snooze_cnt=2. Third snooze is ignored and ringing stays 1.
4. Priority: snooze and stop rise in the same cycle while RINGING -> DISMISSED, snooze_cnt unchanged, missed=0.
5. Disarm and reset mid-operation: en=0 during SNOOZE -> IDLE next cycle, buzz=0. Assert reset during RINGING -> outputs 0 immediately (asynchronous), before the next clk edge.
6. Button held through reset: hold stop high across reset release -> no dismiss until released and re-pressed.
